// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared pipeline definitions for the instruction-fetch stage:
//                datapath width, NOP encoding, HALT opcode and the fetch
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package if_stage_pkg;

    localparam int unsigned c_WIDTH       = 16;
    localparam logic [15:0] c_NOP_INSTR   = 16'h0000;
    localparam logic [3:0]  c_HALT_OPCODE = 4'hF;

    // Fetch state: RUN fetches sequentially, HALT freezes the PC.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_if_id_register.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if_id_register
//  Description : IF/ID pipeline register with flush and hold.
//                Priority per edge: rst > i_flush > i_hold > i_load > NOP.
//                Without flush, hold or load the register takes a NOP
//                bubble (used while fetch is halted).
//  Ports       : clk, rst           clock (negedge active), sync reset
//                i_flush            load a NOP bubble (redirect)
//                i_hold             keep current contents (stall)
//                i_load             capture i_instr / i_addr as valid
//                i_instr, i_addr    fetched word and its PC+1
//                o_instr, o_addr,   registered instruction, PC+1, valid
//                o_valid
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage_if_id_register
    import if_stage_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_hold,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_addr,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_instr_q, w_instr_d;
    logic [WIDTH-1:0] r_addr_q,  w_addr_d;
    logic             r_valid_q, w_valid_d;

    always_comb begin
        w_instr_d = r_instr_q;
        w_addr_d  = r_addr_q;
        w_valid_d = r_valid_q;
        if (i_flush) begin
            w_instr_d = WIDTH'(c_NOP_INSTR);
            w_addr_d  = '0;
            w_valid_d = 1'b0;
        end else if (i_hold) begin
            w_instr_d = r_instr_q;
            w_addr_d  = r_addr_q;
            w_valid_d = r_valid_q;
        end else if (i_load) begin
            w_instr_d = i_instr;
            w_addr_d  = i_addr;
            w_valid_d = 1'b1;
        end else begin
            w_instr_d = WIDTH'(c_NOP_INSTR);
            w_addr_d  = '0;
            w_valid_d = 1'b0;
        end
    end

    // Pipeline registers in this design all update on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_instr_q <= '0;
            r_addr_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_instr_q <= w_instr_d;
            r_addr_q  <= w_addr_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign o_instr = r_instr_q;
    assign o_addr  = r_addr_q;
    assign o_valid = r_valid_q;

endmodule : if_stage_if_id_register
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Owns the PC, drives the
//                instruction-memory address, and feeds the IF/ID register.
//                Handles load-use stall, EX branch redirect, ID jump
//                redirect and a HALT state entered on the HALT opcode.
//  Ports       : clk, reset                   clock (negedge), sync reset
//                stall                        hold PC and IF/ID
//                branch_taken, branch_target  EX redirect (highest)
//                jump, jump_target            ID redirect
//                imem_addr / imem_data        combinational imem read
//                instruction_out, address_out,
//                valid_out                    IF/ID contents
//                halted                       fetch is in HALT
//                fetch_count                  words accepted into IF/ID
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned      WIDTH       = c_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]       HALT_OPCODE = c_HALT_OPCODE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instruction_out,
    output logic [WIDTH-1:0] address_out,
    output logic             valid_out,
    output logic             halted,
    output logic [WIDTH-1:0] fetch_count
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e     r_state_q, w_state_d;
    logic [WIDTH-1:0] r_pc_q,    w_pc_d;
    logic [WIDTH-1:0] r_count_q, w_count_d;

    logic             w_redirect;
    logic             w_fetch;
    logic             w_is_halt;
    logic [WIDTH-1:0] w_pc_inc;

    assign w_redirect = branch_taken | jump;
    assign w_pc_inc   = r_pc_q + c_ONE;
    assign w_is_halt  = (imem_data[WIDTH-1 -: 4] == HALT_OPCODE);
    // A normal fetch happens only in RUN with no redirect and no stall.
    assign w_fetch    = (r_state_q == ST_RUN) && !w_redirect && !stall;

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_count_d = r_count_q;
        if (branch_taken) begin
            w_pc_d    = branch_target;
            w_state_d = ST_RUN;
        end else if (jump) begin
            w_pc_d    = jump_target;
            w_state_d = ST_RUN;
        end else if (w_fetch) begin
            w_count_d = r_count_q + c_ONE;
            if (w_is_halt) begin
                // The halt word is delivered downstream but the PC parks on it.
                w_state_d = ST_HALT;
            end else begin
                w_pc_d = w_pc_inc;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            r_state_q <= ST_RUN;
            r_pc_q    <= RESET_PC;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_count_q <= w_count_d;
        end
    end

    // In HALT a stall has no extra effect: IF/ID keeps taking bubbles.
    if_stage_if_id_register #(
        .WIDTH (WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst     (reset),
        .i_flush (w_redirect),
        .i_hold  (stall && (r_state_q == ST_RUN)),
        .i_load  (w_fetch),
        .i_instr (imem_data),
        .i_addr  (w_pc_inc),
        .o_instr (instruction_out),
        .o_addr  (address_out),
        .o_valid (valid_out)
    );

    assign imem_addr   = r_pc_q;
    assign halted      = (r_state_q == ST_HALT);
    assign fetch_count = r_count_q;

endmodule : if_stage
`default_nettype wire
